// File: rtl/hood_mode_ctrl.sv
// rtl/hood_mode_ctrl.sv - range-hood operating-mode state machine
// Mode, fan speed, seconds countdown and hurricane/self-clean bookkeeping.
module hood_mode_ctrl #(
  parameter int TICKS_PER_SEC = 100,
  parameter int HURRICANE_SEC = 60,
  parameter int RETURN_SEC    = 60,
  parameter int CLEAN_SEC     = 180
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       power_on,
  input  logic       btn_menu,
  input  logic       btn_l1,
  input  logic       btn_l2,
  input  logic       btn_l3,
  input  logic       btn_clean,
  output logic [2:0] mode,
  output logic [1:0] fan_level,
  output logic [7:0] countdown,
  output logic       hurricane_used,
  output logic       clean_done
);

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_STANDBY = 3'd1,
    S_MENU    = 3'd2,
    S_L1      = 3'd3,
    S_L2      = 3'd4,
    S_L3      = 3'd5,
    S_L3_RET  = 3'd6,
    S_CLEAN   = 3'd7
  } state_t;

  localparam logic [7:0] TPS_LAST  = 8'(TICKS_PER_SEC - 1);
  localparam logic [7:0] HURR_LOAD = 8'(HURRICANE_SEC);
  localparam logic [7:0] RET_LOAD  = 8'(RETURN_SEC);
  localparam logic [7:0] CLN_LOAD  = 8'(CLEAN_SEC);

  state_t     state_q, state_d;
  logic [7:0] presc_q, presc_d;
  logic [7:0] cd_q, cd_d;
  logic       hu_q, hu_d;
  logic [1:0] fan_q, fan_d;
  logic       clean_done_q, clean_done_d;

  logic sec_pulse;
  logic expire;

  assign sec_pulse = tick && (presc_q == TPS_LAST);
  assign expire    = sec_pulse && (cd_q == 8'd1);

  always_comb begin
    state_d      = state_q;
    cd_d         = cd_q;
    hu_d         = hu_q;
    clean_done_d = 1'b0;
    presc_d      = presc_q;
    fan_d        = 2'd0;

    if (tick) begin
      presc_d = (presc_q == TPS_LAST) ? 8'd0 : presc_q + 8'd1;
    end
    // countdown is only ever nonzero in timed states, so this is safe everywhere
    if (sec_pulse && cd_q != 8'd0) begin
      cd_d = cd_q - 8'd1;
    end

    if (!power_on) begin
      state_d = S_OFF;
      cd_d    = 8'd0;
      hu_d    = 1'b0;
    end else begin
      case (state_q)
        S_OFF: state_d = S_STANDBY;
        S_STANDBY: begin
          if (btn_menu) state_d = S_MENU;
        end
        S_MENU: begin
          if (btn_menu) begin
            state_d = S_STANDBY;
          end else if (btn_l3 && !hu_q) begin
            state_d = S_L3;
            cd_d    = HURR_LOAD;
            hu_d    = 1'b1;
          end else if (btn_l2) begin
            state_d = S_L2;
          end else if (btn_l1) begin
            state_d = S_L1;
          end else if (btn_clean) begin
            state_d = S_CLEAN;
            cd_d    = CLN_LOAD;
          end
        end
        S_L1, S_L2: begin
          if (btn_menu)    state_d = S_STANDBY;
          else if (btn_l2) state_d = S_L2;
          else if (btn_l1) state_d = S_L1;
        end
        S_L3: begin
          // expiry beats a menu press landing on the same edge
          if (expire) begin
            state_d = S_L2;
          end else if (btn_menu) begin
            state_d = S_L3_RET;
            cd_d    = RET_LOAD;
          end
        end
        S_L3_RET: begin
          if (expire) state_d = S_STANDBY;
        end
        S_CLEAN: begin
          if (expire) begin
            state_d      = S_STANDBY;
            clean_done_d = 1'b1;
          end
        end
        default: state_d = S_OFF;
      endcase
    end

    if (state_d != state_q) begin
      presc_d = 8'd0;
    end

    case (state_d)
      S_L1:              fan_d = 2'd1;
      S_L2:              fan_d = 2'd2;
      S_L3, S_L3_RET:    fan_d = 2'd3;
      default:           fan_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_OFF;
      presc_q      <= 8'd0;
      cd_q         <= 8'd0;
      hu_q         <= 1'b0;
      fan_q        <= 2'd0;
      clean_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      cd_q         <= cd_d;
      hu_q         <= hu_d;
      fan_q        <= fan_d;
      clean_done_q <= clean_done_d;
    end
  end

  assign mode           = state_q;
  assign fan_level      = fan_q;
  assign countdown      = cd_q;
  assign hurricane_used = hu_q;
  assign clean_done     = clean_done_q;

endmodule

// File: tb/tb_hood_mode_ctrl.sv
// tb/tb_hood_mode_ctrl.sv - self-checking bench for hood_mode_ctrl
// Directed plan scenarios followed by randomized stimulus against a reference model.
module tb_hood_mode_ctrl;

  localparam int TPS = 4;
  localparam int HS  = 3;
  localparam int RS  = 2;
  localparam int CS  = 2;

  localparam logic [4:0] B_MENU  = 5'b00001;
  localparam logic [4:0] B_L1    = 5'b00010;
  localparam logic [4:0] B_L2    = 5'b00100;
  localparam logic [4:0] B_L3    = 5'b01000;
  localparam logic [4:0] B_CLEAN = 5'b10000;

  localparam int M_OFF = 0, M_STBY = 1, M_MENU = 2, M_L1 = 3, M_L2 = 4,
                 M_L3 = 5, M_RET = 6, M_CLEAN = 7;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       power_on = 1'b0;
  logic       btn_menu = 1'b0, btn_l1 = 1'b0, btn_l2 = 1'b0, btn_l3 = 1'b0, btn_clean = 1'b0;
  logic [2:0] mode;
  logic [1:0] fan_level;
  logic [7:0] countdown;
  logic       hurricane_used;
  logic       clean_done;

  int tests = 0;
  int fails = 0;

  hood_mode_ctrl #(
    .TICKS_PER_SEC(TPS),
    .HURRICANE_SEC(HS),
    .RETURN_SEC(RS),
    .CLEAN_SEC(CS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tick(tick),
    .power_on(power_on),
    .btn_menu(btn_menu),
    .btn_l1(btn_l1),
    .btn_l2(btn_l2),
    .btn_l3(btn_l3),
    .btn_clean(btn_clean),
    .mode(mode),
    .fan_level(fan_level),
    .countdown(countdown),
    .hurricane_used(hurricane_used),
    .clean_done(clean_done)
  );

  always #5 clk = ~clk;

  // Reference model: mode, seconds left, ticks counted in the current mode
  int m_mode = M_OFF;
  int m_cd   = 0;
  int m_hu   = 0;
  int m_pc   = 0;
  int m_cdn  = 0;

  function automatic int fan_of(input int md);
    if (md == M_L1) return 1;
    if (md == M_L2) return 2;
    if (md == M_L3 || md == M_RET) return 3;
    return 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int  nm;
    bit  sp;
    nm = m_mode;
    m_cdn = 0;
    if (reset) begin
      m_mode = M_OFF; m_cd = 0; m_hu = 0; m_pc = 0;
    end else begin
      sp = tick && (m_pc == TPS - 1);
      if (tick) m_pc = (m_pc + 1) % TPS;
      if (!power_on) begin
        nm = M_OFF; m_cd = 0; m_hu = 0;
      end else begin
        case (m_mode)
          M_OFF:  nm = M_STBY;
          M_STBY: if (btn_menu) nm = M_MENU;
          M_MENU: begin
            if (btn_menu) nm = M_STBY;
            else if (btn_l3 && m_hu == 0) begin nm = M_L3; m_cd = HS; m_hu = 1; end
            else if (btn_l2) nm = M_L2;
            else if (btn_l1) nm = M_L1;
            else if (btn_clean) begin nm = M_CLEAN; m_cd = CS; end
          end
          M_L1, M_L2: begin
            if (btn_menu) nm = M_STBY;
            else if (btn_l2) nm = M_L2;
            else if (btn_l1) nm = M_L1;
          end
          M_L3: begin
            if (sp && m_cd == 1) begin nm = M_L2; m_cd = 0; end
            else if (btn_menu) begin nm = M_RET; m_cd = RS; end
            else if (sp && m_cd > 0) m_cd--;
          end
          default: begin
            if (sp && m_cd > 0) begin
              m_cd--;
              if (m_cd == 0) begin
                if (m_mode == M_CLEAN) m_cdn = 1;
                nm = M_STBY;
              end
            end
          end
        endcase
      end
      if (nm != m_mode) m_pc = 0;
      m_mode = nm;
    end
    #1;
    chk("mode", int'(mode), m_mode);
    chk("fan_level", int'(fan_level), fan_of(m_mode));
    chk("countdown", int'(countdown), m_cd);
    chk("hurricane_used", int'(hurricane_used), m_hu);
    chk("clean_done", int'(clean_done), m_cdn);
  end

  task automatic step(input logic [4:0] b, input logic tk, input logic pw, input logic rst);
    @(negedge clk);
    {btn_clean, btn_l3, btn_l2, btn_l1, btn_menu} = b;
    tick = tk;
    power_on = pw;
    reset = rst;
    @(posedge clk);
    #2;
    {btn_clean, btn_l3, btn_l2, btn_l1, btn_menu} = 5'b0;
    tick = 1'b0;
  endtask

  task automatic press(input logic [4:0] b);
    step(b, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(5'b0, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    int cd_pulses;
    step(5'b0, 1'b0, 1'b0, 1'b1);
    step(5'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_mode", int'(mode), 0);
    chk("rst_fan", int'(fan_level), 0);
    chk("rst_cd", int'(countdown), 0);
    chk("rst_hu", int'(hurricane_used), 0);
    chk("rst_cdone", int'(clean_done), 0);

    // 1: hurricane entry and automatic drop to L2
    step(5'b0, 1'b0, 1'b1, 1'b0);
    chk("t1_standby", int'(mode), 1);
    press(B_MENU);
    press(B_L3);
    chk("t1_mode", int'(mode), 5);
    chk("t1_fan", int'(fan_level), 3);
    chk("t1_cd", int'(countdown), 3);
    ticks(4);  chk("t1_cd2", int'(countdown), 2);
    ticks(4);  chk("t1_cd1", int'(countdown), 1);
    ticks(3);  chk("t1_hold", int'(mode), 5);
    ticks(1);
    chk("t1_l2", int'(mode), 4);
    chk("t1_cd0", int'(countdown), 0);

    // 2: hurricane is one-shot per session
    press(B_MENU);
    press(B_MENU);
    press(B_L3);
    chk("t2_menu", int'(mode), 2);
    chk("t2_hu", int'(hurricane_used), 1);
    step(5'b0, 1'b0, 1'b0, 1'b0);
    chk("t2_off", int'(mode), 0);
    chk("t2_hu0", int'(hurricane_used), 0);
    step(5'b0, 1'b0, 1'b1, 1'b0);
    press(B_MENU);
    press(B_L3);
    chk("t2_l3", int'(mode), 5);

    // 3: menu from L3 starts return timer
    press(B_MENU);
    chk("t3_ret", int'(mode), 6);
    chk("t3_cd", int'(countdown), 2);
    chk("t3_fan", int'(fan_level), 3);
    ticks(8);
    chk("t3_stby", int'(mode), 1);
    chk("t3_fan0", int'(fan_level), 0);
    chk("t3_cd0", int'(countdown), 0);

    // 4: self-clean ignores keys, pulses clean_done once
    press(B_MENU);
    press(B_CLEAN);
    chk("t4_clean", int'(mode), 7);
    cd_pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step(5'(1 << (i % 5)), 1'b1, 1'b1, 1'b0);
      if (clean_done) cd_pulses++;
      if (i < 7) chk("t4_hold", int'(mode), 7);
    end
    chk("t4_stby", int'(mode), 1);
    chk("t4_cdone", int'(clean_done), 1);
    step(5'b0, 1'b0, 1'b1, 1'b0);
    if (clean_done) cd_pulses++;
    chk("t4_pulses", cd_pulses, 1);

    // 5a: l1+l2 together from MENU
    press(B_MENU);
    press(B_L1 | B_L2);
    chk("t5a_l2", int'(mode), 4);

    // 5b: final second and menu on the same edge
    step(5'b0, 1'b0, 1'b0, 1'b0);
    step(5'b0, 1'b0, 1'b1, 1'b0);
    press(B_MENU);
    press(B_L3);
    ticks(11);
    chk("t5b_cd1", int'(countdown), 1);
    step(B_MENU, 1'b1, 1'b1, 1'b0);
    chk("t5b_l2", int'(mode), 4);
    chk("t5b_cd0", int'(countdown), 0);

    // 6: reset on the very edge clean would expire
    press(B_MENU);
    press(B_MENU);
    press(B_CLEAN);
    ticks(7);
    chk("t6_cd1", int'(countdown), 1);
    step(5'b0, 1'b1, 1'b1, 1'b1);
    chk("t6_mode", int'(mode), 0);
    chk("t6_cd", int'(countdown), 0);
    chk("t6_cdone", int'(clean_done), 0);
    for (int i = 0; i < 3; i++) begin
      step(5'b0, 1'b1, 1'b1, 1'b0);
      chk("t6_nopulse", int'(clean_done), 0);
    end

    // randomized phase, checked every cycle by the model
    for (int i = 0; i < 4000; i++) begin
      logic [4:0] b;
      for (int k = 0; k < 5; k++) b[k] = ($urandom_range(0, 5) == 0);
      step(b, 1'($urandom_range(0, 1)), ($urandom_range(0, 149) != 0),
           ($urandom_range(0, 499) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
